// File: rtl/bcd_accum_seq_pkg.sv
// Shared constants for the digit-serial BCD accumulator: opcodes, FSM states
// and decimal digit limits.
package bcd_accum_seq_pkg;

    localparam logic [1:0] OP_CLEAR = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_ADD   = 2'd2;
    localparam logic [1:0] OP_SUB   = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    // Subtraction is done as addition of the nine's complement plus an initial carry.
    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return BCD_MAX - digit;
    endfunction

endpackage

// File: rtl/bcd_accum_seq_digit_add.sv
// Single-digit BCD adder: binary sum of two digits and a carry, with the
// +6 decimal correction whenever the sum exceeds nine.
module bcd_digit_add
    import bcd_accum_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] d,
    output logic       cout
);

    logic [4:0] s;

    always_comb begin
        s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        if (s > {1'b0, BCD_MAX}) begin
            d    = s[3:0] + BCD_ADJ;
            cout = 1'b1;
        end else begin
            d    = s[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_accum_seq.sv
// Digit-serial packed-BCD accumulator: CLEAR/LOAD complete in one step,
// ADD/SUB walk the digits least-significant first through one shared digit adder.
module bcd_accum_seq
    import bcd_accum_seq_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          op,
    input  logic [4*DIGITS-1:0] operand,
    output logic [4*DIGITS-1:0] acc,
    output logic                done,
    output logic                carry,
    output logic                err
);

    logic [1:0]          state;
    logic [CNT_W-1:0]    idx;
    logic [1:0]          op_r;
    logic [4*DIGITS-1:0] opnd_r;
    logic [4*DIGITS-1:0] acc_r;
    logic                c_r;
    logic                carry_r;
    logic                done_r;
    logic                err_r;

    logic [DIGITS-1:0]   nib_bad;
    logic                operand_bad;
    logic [3:0]          a_dig;
    logic [3:0]          b_raw;
    logic [3:0]          b_dig;
    logic [3:0]          sum_dig;
    logic                sum_cout;
    logic                last_dig;

    for (genvar g = 0; g < DIGITS; g++) begin : g_check
        assign nib_bad[g] = operand[4*g +: 4] > BCD_MAX;
    end
    assign operand_bad = |nib_bad;

    assign a_dig    = acc_r[4*int'(idx) +: 4];
    assign b_raw    = opnd_r[4*int'(idx) +: 4];
    assign b_dig    = (op_r == OP_SUB) ? nines_comp(b_raw) : b_raw;
    assign last_dig = (idx == CNT_W'(DIGITS - 1));

    bcd_digit_add u_digit_add (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (c_r),
        .d    (sum_dig),
        .cout (sum_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            op_r    <= OP_CLEAR;
            opnd_r  <= '0;
            acc_r   <= '0;
            c_r     <= 1'b0;
            carry_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (op != OP_CLEAR && operand_bad) begin
                            err_r <= 1'b1;
                        end else begin
                            case (op)
                                OP_CLEAR: begin
                                    acc_r   <= '0;
                                    carry_r <= 1'b0;
                                    done_r  <= 1'b1;
                                end
                                OP_LOAD: begin
                                    acc_r   <= operand;
                                    carry_r <= 1'b0;
                                    done_r  <= 1'b1;
                                end
                                default: begin
                                    op_r   <= op;
                                    opnd_r <= operand;
                                    idx    <= '0;
                                    c_r    <= (op == OP_SUB);
                                    state  <= ST_RUN;
                                end
                            endcase
                        end
                    end
                end
                // Final carry is inverted for SUB so that carry reports a borrow.
                ST_RUN: begin
                    acc_r[4*int'(idx) +: 4] <= sum_dig;
                    c_r <= sum_cout;
                    if (last_dig) begin
                        idx     <= '0;
                        done_r  <= 1'b1;
                        carry_r <= (op_r == OP_SUB) ? ~sum_cout : sum_cout;
                        state   <= ST_DONE;
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready = (state == ST_IDLE);
    assign acc      = acc_r;
    assign done     = done_r;
    assign carry    = carry_r;
    assign err      = err_r;

endmodule
